// File: rtl/seg7_scan_reader.sv
// Recovers BCD digits from a multiplexed 7-segment bus: filters unstable
// segment/select pairs, assembles an in-order scan frame and emits it with a valid pulse.
module seg7_scan_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic [NUM_DIGITS-1:0]   err_mask,
    output logic                    frame_valid,
    output logic                    frame_drop
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int KW = $clog2(NUM_DIGITS + 1);

    typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_t;

    state_t                  state_reg;
    logic [6:0]              seg_q;
    logic [NUM_DIGITS-1:0]   sel_q;
    logic [CW-1:0]           cnt_reg;
    logic [CW-1:0]           cnt_next;
    logic [KW-1:0]           k_reg;
    logic [3:0]              stage_bcd_reg [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   stage_err_reg;
    logic [3:0]              bcd_reg [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   err_mask_reg;
    logic                    frame_valid_reg;
    logic                    frame_drop_reg;

    logic                    in_onehot;
    logic                    in_changed;
    logic                    capture;
    logic [IW-1:0]           sel_idx;
    logic [3:0]              dec_nib;
    logic                    dec_err;

    // The stability count tracks the value the input registers are about to take.
    always_comb begin
        in_onehot  = (dig_sel != '0) && ((dig_sel & (dig_sel - 1'b1)) == '0);
        in_changed = (seg_in != seg_q) || (dig_sel != sel_q);
        cnt_next   = cnt_reg;
        if (!in_onehot)
            cnt_next = '0;
        else if (in_changed)
            cnt_next = CW'(1);
        else if (cnt_reg != CW'(STABLE_CYCLES))
            cnt_next = cnt_reg + 1'b1;
        capture = in_onehot && !in_changed && (cnt_reg == CW'(STABLE_CYCLES - 1));
    end

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (sel_q[i])
                sel_idx = IW'(i);
    end

    always_comb begin
        dec_err = 1'b0;
        case (seg_q)
            7'b1111110: dec_nib = 4'h0;
            7'b0110000: dec_nib = 4'h1;
            7'b1101101: dec_nib = 4'h2;
            7'b1111001: dec_nib = 4'h3;
            7'b0110011: dec_nib = 4'h4;
            7'b1011011: dec_nib = 4'h5;
            7'b1011111: dec_nib = 4'h6;
            7'b1110010: dec_nib = 4'h7;
            7'b1111111: dec_nib = 4'h8;
            7'b1111011: dec_nib = 4'h9;
            7'b0000000: dec_nib = 4'hF;
            default: begin
                dec_nib = 4'hE;
                dec_err = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q           <= '0;
            sel_q           <= '0;
            cnt_reg         <= '0;
            state_reg       <= IDLE;
            k_reg           <= '0;
            stage_err_reg   <= '0;
            err_mask_reg    <= '0;
            frame_valid_reg <= 1'b0;
            frame_drop_reg  <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                stage_bcd_reg[i] <= '0;
                bcd_reg[i]       <= '0;
            end
        end else begin
            seg_q           <= seg_in;
            sel_q           <= dig_sel;
            cnt_reg         <= cnt_next;
            frame_valid_reg <= 1'b0;
            frame_drop_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (capture && sel_idx == '0) begin
                        stage_bcd_reg[0] <= dec_nib;
                        stage_err_reg[0] <= dec_err;
                        k_reg            <= KW'(1);
                        state_reg        <= (NUM_DIGITS == 1) ? EMIT : COLLECT;
                    end
                end
                COLLECT: begin
                    if (capture) begin
                        if (sel_idx == '0) begin
                            stage_bcd_reg[0] <= dec_nib;
                            stage_err_reg[0] <= dec_err;
                            k_reg            <= KW'(1);
                        end else if (KW'(sel_idx) == k_reg) begin
                            stage_bcd_reg[sel_idx] <= dec_nib;
                            stage_err_reg[sel_idx] <= dec_err;
                            k_reg                  <= k_reg + 1'b1;
                            if (k_reg == KW'(NUM_DIGITS - 1))
                                state_reg <= EMIT;
                        end else begin
                            // Out-of-order digit: abandon the partial frame entirely.
                            frame_drop_reg <= 1'b1;
                            stage_err_reg  <= '0;
                            k_reg          <= '0;
                            state_reg      <= IDLE;
                            for (int i = 0; i < NUM_DIGITS; i++)
                                stage_bcd_reg[i] <= '0;
                        end
                    end
                end
                EMIT: begin
                    for (int i = 0; i < NUM_DIGITS; i++)
                        bcd_reg[i] <= stage_bcd_reg[i];
                    err_mask_reg    <= stage_err_reg;
                    frame_valid_reg <= 1'b1;
                    k_reg           <= '0;
                    state_reg       <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_out
            assign bcd_out[4*gi +: 4] = bcd_reg[gi];
        end
    endgenerate

    assign err_mask    = err_mask_reg;
    assign frame_valid = frame_valid_reg;
    assign frame_drop  = frame_drop_reg;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed bench for seg7_scan_reader: scans digit sequences onto the bus and
// checks the recovered frames, error flags and valid/drop pulses.
module tb_seg7_scan_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  seg_in = '0;
    logic [3:0]  dig_sel = '0;
    logic [15:0] bcd_out;
    logic [3:0]  err_mask;
    logic        frame_valid;
    logic        frame_drop;

    int tests = 0;
    int fails = 0;
    int vld_cnt = 0;
    int drop_cnt = 0;

    localparam logic [6:0] P0 = 7'b1111110, P1 = 7'b0110000, P2 = 7'b1101101,
                           P3 = 7'b1111001, P4 = 7'b0110011, P5 = 7'b1011011,
                           P6 = 7'b1011111, P7 = 7'b1110010, P8 = 7'b1111111,
                           P9 = 7'b1111011, PB = 7'b0000000, PX = 7'b0000001;

    seg7_scan_reader #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .seg_in(seg_in), .dig_sel(dig_sel),
        .bcd_out(bcd_out), .err_mask(err_mask),
        .frame_valid(frame_valid), .frame_drop(frame_drop)
    );

    always #5 clk = ~clk;

    // Pulse counters sample shortly after each rising edge, clear of the drive edge.
    always @(posedge clk) begin
        #2;
        if (frame_valid) vld_cnt++;
        if (frame_drop)  drop_cnt++;
    end

    task automatic send(input logic [6:0] seg, input logic [3:0] sel, input int n);
        seg_in  = seg;
        dig_sel = sel;
        $display("[TB] seg=%b sel=%b held %0d cycles", seg, sel, n);
        repeat (n) @(negedge clk);
    endtask

    task automatic scan4(input logic [6:0] p0, input logic [6:0] p1,
                         input logic [6:0] p2, input logic [6:0] p3);
        send(p0, 4'b0001, 6);
        send(p1, 4'b0010, 6);
        send(p2, 4'b0100, 6);
        send(p3, 4'b1000, 6);
        send(PB, 4'b0000, 3);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (bcd_out !== 16'h0000) begin fails++; $display("FAIL reset_bcd got %h exp 0000", bcd_out); end
        tests++; if (err_mask !== 4'b0000) begin fails++; $display("FAIL reset_err got %b exp 0000", err_mask); end
        tests++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", frame_valid); end
        tests++; if (frame_drop !== 1'b0) begin fails++; $display("FAIL reset_drop got %b exp 0", frame_drop); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int v0 = vld_cnt;
        int d0 = drop_cnt;
        send(P1, 4'b0001, 6);
        send(P2, 4'b0010, 6);
        send(P3, 4'b0100, 6);
        send(P4, 4'b1000, 4);
        tests++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL basic_early_valid got %b exp 0", frame_valid); end
        @(negedge clk);
        tests++; if (frame_valid !== 1'b1) begin fails++; $display("FAIL basic_valid_edge5 got %b exp 1", frame_valid); end
        tests++; if (bcd_out !== 16'h4321) begin fails++; $display("FAIL basic_bcd got %h exp 4321", bcd_out); end
        tests++; if (err_mask !== 4'b0000) begin fails++; $display("FAIL basic_err got %b exp 0000", err_mask); end
        @(negedge clk);
        tests++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL basic_valid_width got %b exp 0", frame_valid); end
        send(PB, 4'b0000, 3);
        tests++; if (vld_cnt - v0 !== 1) begin fails++; $display("FAIL basic_valid_count got %0d exp 1", vld_cnt - v0); end
        tests++; if (drop_cnt - d0 !== 0) begin fails++; $display("FAIL basic_drop_count got %0d exp 0", drop_cnt - d0); end
    endtask

    task automatic test_short_digit;
        int v0 = vld_cnt;
        int d0 = drop_cnt;
        send(P5, 4'b0001, 6);
        send(P6, 4'b0010, 6);
        send(P7, 4'b0100, 3);
        send(P8, 4'b1000, 6);
        send(PB, 4'b0000, 3);
        tests++; if (drop_cnt - d0 !== 1) begin fails++; $display("FAIL short_drop_count got %0d exp 1", drop_cnt - d0); end
        tests++; if (vld_cnt - v0 !== 0) begin fails++; $display("FAIL short_valid_count got %0d exp 0", vld_cnt - v0); end
        tests++; if (bcd_out !== 16'h4321) begin fails++; $display("FAIL short_bcd_hold got %h exp 4321", bcd_out); end
    endtask

    task automatic test_invalid;
        int v0 = vld_cnt;
        scan4(P0, PB, PX, P5);
        tests++; if (bcd_out !== 16'h5EF0) begin fails++; $display("FAIL invalid_bcd got %h exp 5EF0", bcd_out); end
        tests++; if (err_mask !== 4'b0100) begin fails++; $display("FAIL invalid_err got %b exp 0100", err_mask); end
        tests++; if (vld_cnt - v0 !== 1) begin fails++; $display("FAIL invalid_valid_count got %0d exp 1", vld_cnt - v0); end
    endtask

    task automatic test_out_of_order;
        int v0 = vld_cnt;
        int d0 = drop_cnt;
        send(P1, 4'b0001, 6);
        send(P2, 4'b0010, 6);
        send(P4, 4'b1000, 6);
        tests++; if (drop_cnt - d0 !== 1) begin fails++; $display("FAIL order_drop_count got %0d exp 1", drop_cnt - d0); end
        tests++; if (bcd_out !== 16'h5EF0) begin fails++; $display("FAIL order_bcd_hold got %h exp 5EF0", bcd_out); end
        scan4(P9, P8, P7, P6);
        tests++; if (bcd_out !== 16'h6789) begin fails++; $display("FAIL order_bcd got %h exp 6789", bcd_out); end
        tests++; if (err_mask !== 4'b0000) begin fails++; $display("FAIL order_err got %b exp 0000", err_mask); end
        tests++; if (vld_cnt - v0 !== 1) begin fails++; $display("FAIL order_valid_count got %0d exp 1", vld_cnt - v0); end
    endtask

    task automatic test_multi_sel;
        int v0 = vld_cnt;
        int d0 = drop_cnt;
        send(P1, 4'b0011, 10);
        tests++; if (vld_cnt - v0 !== 0) begin fails++; $display("FAIL multi_valid_count got %0d exp 0", vld_cnt - v0); end
        tests++; if (drop_cnt - d0 !== 0) begin fails++; $display("FAIL multi_drop_count got %0d exp 0", drop_cnt - d0); end
        scan4(P5, P6, P7, P8);
        tests++; if (bcd_out !== 16'h8765) begin fails++; $display("FAIL multi_bcd got %h exp 8765", bcd_out); end
        tests++; if (vld_cnt - v0 !== 1) begin fails++; $display("FAIL multi_frame_count got %0d exp 1", vld_cnt - v0); end
    endtask

    task automatic test_restart;
        int v0 = vld_cnt;
        int d0 = drop_cnt;
        send(P1, 4'b0001, 6);
        send(P2, 4'b0010, 6);
        scan4(P3, P4, P5, P6);
        tests++; if (drop_cnt - d0 !== 0) begin fails++; $display("FAIL restart_drop_count got %0d exp 0", drop_cnt - d0); end
        tests++; if (vld_cnt - v0 !== 1) begin fails++; $display("FAIL restart_valid_count got %0d exp 1", vld_cnt - v0); end
        tests++; if (bcd_out !== 16'h6543) begin fails++; $display("FAIL restart_bcd got %h exp 6543", bcd_out); end
    endtask

    task automatic test_reset_mid;
        int v0;
        scan4(P1, P2, P3, P4);
        tests++; if (bcd_out !== 16'h4321) begin fails++; $display("FAIL rmid_pre_bcd got %h exp 4321", bcd_out); end
        send(P9, 4'b0001, 6);
        send(P9, 4'b0010, 6);
        seg_in  = PB;
        dig_sel = 4'b0000;
        reset   = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests++; if (bcd_out !== 16'h0000) begin fails++; $display("FAIL rmid_bcd got %h exp 0000", bcd_out); end
        tests++; if (err_mask !== 4'b0000) begin fails++; $display("FAIL rmid_err got %b exp 0000", err_mask); end
        v0 = vld_cnt;
        send(P7, 4'b0100, 6);
        send(P8, 4'b1000, 6);
        send(PB, 4'b0000, 3);
        tests++; if (vld_cnt - v0 !== 0) begin fails++; $display("FAIL rmid_partial_valid got %0d exp 0", vld_cnt - v0); end
        tests++; if (bcd_out !== 16'h0000) begin fails++; $display("FAIL rmid_partial_bcd got %h exp 0000", bcd_out); end
        scan4(P1, P2, P3, P4);
        tests++; if (vld_cnt - v0 !== 1) begin fails++; $display("FAIL rmid_frame_count got %0d exp 1", vld_cnt - v0); end
        tests++; if (bcd_out !== 16'h4321) begin fails++; $display("FAIL rmid_bcd_after got %h exp 4321", bcd_out); end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_basic;
        test_short_digit;
        test_invalid;
        test_out_of_order;
        test_multi_sel;
        test_restart;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
